// File: rtl/map_pkg.sv
// Shared types and constants for the tile-ID map write path.
// Command format, opcode and FSM state encodings used by the writer and its FIFO.
package map_pkg;

    localparam int MAP_W      = 11;
    localparam int MAP_H      = 11;
    localparam int MAP_CELLS  = MAP_W * MAP_H;
    localparam int MAP_ADDR_W = 7;

    typedef enum logic {
        OP_WRITE,
        OP_FILL
    } map_op_t;

    typedef struct packed {
        map_op_t    op;
        logic [3:0] row;
        logic [3:0] col;
        logic [7:0] tile;
    } map_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FILL
    } map_state_t;

endpackage

// File: rtl/map_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and a read-first pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module map_cmd_fifo
    import map_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  map_cmd_t wr_data,
    output map_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    map_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/map_tile_writer.sv
// Turns queued WRITE/FILL commands into one-cell-per-cycle map RAM writes,
// issuing writes only while VBlank is high so scanout never sees a partial update.
module map_tile_writer
    import map_pkg::*;
#(
    parameter int MAP_W      = 11,
    parameter int MAP_H      = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              VBlank,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [3:0]        cmd_row,
    input  logic [3:0]        cmd_col,
    input  logic [7:0]        cmd_tile,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [7:0]        WDATA,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);

    map_state_t        state, state_next;
    map_cmd_t          fifo_in, fifo_head;
    logic              fifo_full, fifo_empty, push, pop;
    logic [3:0]        row_q, col_q, row_next, col_next;
    logic [7:0]        tile_q, tile_next, data_next;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_next, cell_addr, addr_next;
    logic              we_next, done_next, err_next;

    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & ~fifo_full;
    assign fifo_in   = '{op: map_op_t'(cmd_op), row: cmd_row, col: cmd_col, tile: cmd_tile};

    map_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .reset   (Reset),
        .push    (push),
        .pop     (pop),
        .wr_data (fifo_in),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Cell address comes from the registered command, never from cmd_* directly.
    assign cell_addr = ADDR_W'(row_q) * ADDR_W'(MAP_W) + ADDR_W'(col_q);

    always_comb begin
        state_next    = state;
        row_next      = row_q;
        col_next      = col_q;
        tile_next     = tile_q;
        fill_cnt_next = fill_cnt;
        pop           = 1'b0;
        we_next       = 1'b0;
        addr_next     = WADDR;
        data_next     = WDATA;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    row_next  = fifo_head.row;
                    col_next  = fifo_head.col;
                    tile_next = fifo_head.tile;
                    if (fifo_head.op == OP_FILL) begin
                        fill_cnt_next = '0;
                        state_next    = ST_FILL;
                    end else if (int'(fifo_head.row) >= MAP_H || int'(fifo_head.col) >= MAP_W) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (VBlank) begin
                    we_next    = 1'b1;
                    addr_next  = cell_addr;
                    data_next  = tile_q;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (VBlank) begin
                    we_next   = 1'b1;
                    addr_next = fill_cnt;
                    data_next = tile_q;
                    if (fill_cnt == LAST_ADDR) begin
                        done_next     = 1'b1;
                        fill_cnt_next = '0;
                        state_next    = ST_IDLE;
                    end else begin
                        fill_cnt_next = fill_cnt + ADDR_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            tile_q   <= '0;
            fill_cnt <= '0;
            WE       <= 1'b0;
            WADDR    <= '0;
            WDATA    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            row_q    <= row_next;
            col_q    <= col_next;
            tile_q   <= tile_next;
            fill_cnt <= fill_cnt_next;
            WE       <= we_next;
            WADDR    <= addr_next;
            WDATA    <= data_next;
            done     <= done_next;
            err      <= err_next;
            busy     <= (state != ST_IDLE) | ~fifo_empty;
        end
    end

endmodule

// File: tb/tb_map_tile_writer.sv
// Directed bench for map_tile_writer: expected RAM writes are queued as commands
// are issued and matched against the write port by a negedge monitor.
module tb_map_tile_writer;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       VBlank = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [3:0] cmd_row = '0;
    logic [3:0] cmd_col = '0;
    logic [7:0] cmd_tile = '0;
    logic       WE;
    logic [6:0] WADDR;
    logic [7:0] WDATA;
    logic       busy, done, err;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   we_total = 0;
    int   err_total = 0;
    logic vb_q = 1'b0;

    map_tile_writer dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .VBlank    (VBlank),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_tile  (cmd_tile),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input int addr, input logic [7:0] data, input logic last);
        exp_t e;
        e.addr = 7'(addr);
        e.data = data;
        e.done = last;
        sb.push_back(e);
    endtask

    task automatic send(input logic op, input logic [3:0] row, input logic [3:0] col,
                        input logic [7:0] tile);
        int k = 0;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_tile  = tile;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && k < 500) begin
            step();
            k++;
        end
        check("send_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle);
        int k = 0;
        step();
        while (busy !== 1'b0 && k < 2000) begin
            if (toggle) VBlank = (((k / 10) % 2) == 0);
            step();
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    // VBlank as seen by the edge that produced the current outputs.
    always @(posedge CLK) vb_q = VBlank;

    always @(negedge CLK) begin
        if (err === 1'b1) err_total++;
        if (WE === 1'b1) begin
            we_total++;
            check("we_in_vblank", vb_q, 1'b1);
            check("we_with_err", err, 1'b0);
            check("we_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("waddr", WADDR, mon_e.addr);
                check("wdata", WDATA, mon_e.data);
                check("done_flag", done, mon_e.done);
            end
        end else if (done === 1'b1) begin
            check("done_without_we", WE, 1'b1);
        end
    end

    initial begin
        int we_base, err_base, k;

        // Reset values
        repeat (2) step();
        Reset = 1'b0;
        check("rst_we", WE, 1'b0);
        check("rst_waddr", WADDR, 7'd0);
        check("rst_wdata", WDATA, 8'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);

        // Single WRITE with VBlank high: WE two edges after acceptance
        VBlank = 1'b1;
        expect_write(25, 8'h1F, 1'b1);
        send(1'b0, 4'd2, 4'd3, 8'h1F);
        check("w1_we_n", WE, 1'b0);
        step();
        check("w1_we_n1", WE, 1'b0);
        check("w1_busy_n1", busy, 1'b1);
        step();
        check("w1_we_n2", WE, 1'b1);
        check("w1_addr", WADDR, 7'd25);
        check("w1_data", WDATA, 8'h1F);
        check("w1_done", done, 1'b1);
        check("w1_busy_n2", busy, 1'b1);
        step();
        check("w1_busy_fall", busy, 1'b0);
        check("w1_we_off", WE, 1'b0);
        check("w1_done_off", done, 1'b0);

        // WRITE held off by VBlank low for 50 cycles
        VBlank = 1'b0;
        expect_write(25, 8'h1F, 1'b1);
        send(1'b0, 4'd2, 4'd3, 8'h1F);
        we_base = we_total;
        repeat (50) step();
        check("w2_no_we_low", we_total, we_base);
        check("w2_busy_wait", busy, 1'b1);
        VBlank = 1'b1;
        step();
        check("w2_we_first_high", WE, 1'b1);
        check("w2_addr", WADDR, 7'd25);
        wait_idle(1'b0);

        // FILL with VBlank toggling 10 high / 10 low
        for (int i = 0; i < 121; i++) expect_write(i, 8'h07, (i == 120));
        we_base = we_total;
        send(1'b1, 4'd0, 4'd0, 8'h07);
        wait_idle(1'b1);
        VBlank = 1'b1;
        check("fill_we_count", we_total - we_base, 121);
        check("fill_sb_drained", sb.size(), 0);

        // Out-of-range WRITE is discarded with err, next WRITE still lands
        we_base  = we_total;
        err_base = err_total;
        send(1'b0, 4'd11, 4'd0, 8'h33);
        expect_write(120, 8'h44, 1'b1);
        send(1'b0, 4'd10, 4'd10, 8'h44);
        wait_idle(1'b0);
        check("oor_err_count", err_total - err_base, 1);
        check("oor_we_count", we_total - we_base, 1);

        // Back-to-back pushes while VBlank is low fill the FIFO
        VBlank = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_write(i, 8'hA0 + 8'(i), 1'b1);
            send(1'b0, 4'd0, 4'(i), 8'hA0 + 8'(i));
        end
        check("full_ready_low", cmd_ready, 1'b0);
        expect_write(5, 8'hA5, 1'b1);
        cmd_op    = 1'b0;
        cmd_row   = 4'd0;
        cmd_col   = 4'd5;
        cmd_tile  = 8'hA5;
        cmd_valid = 1'b1;
        repeat (5) step();
        check("full_ready_held", cmd_ready, 1'b0);
        VBlank = 1'b1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("full_ready_frees", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        wait_idle(1'b0);
        check("full_sb_drained", sb.size(), 0);

        // Reset partway through a FILL with two commands queued behind it
        for (int i = 0; i < 60; i++) expect_write(i, 8'h55, 1'b0);
        send(1'b1, 4'd0, 4'd0, 8'h55);
        send(1'b0, 4'd1, 4'd1, 8'h66);
        send(1'b0, 4'd1, 4'd2, 8'h77);
        k = 0;
        while (!(WE === 1'b1 && WADDR === 7'd59) && k < 300) begin
            step();
            k++;
        end
        check("rst_fill_reach_59", WADDR, 7'd59);
        Reset = 1'b1;
        step();
        check("rstmid_we", WE, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b1);
        Reset = 1'b0;
        we_base = we_total;
        repeat (20) step();
        check("rstmid_no_writes", we_total, we_base);
        check("rstmid_fifo_empty", busy, 1'b0);
        check("rstmid_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
